// File: rtl/level_sequencer_if.sv
// level_sequencer_if: groups the sequencer's collision inputs and game-flow outputs.
// Latency: none; this is wiring only.
// Backpressure: none; all signals are plain levels or single-cycle pulses.
// Ports: master = the sequencer (drives level/spawn/load_pos/move_en/lives/state_o),
//        slave  = collision detect plus renderer side (drives tick/start/hit_*).
// Optional: `define LEVEL_SEQUENCER_CHECKPOINT_EN adds the ckpt_x/ckpt_y location inputs.
interface level_sequencer_if;
   logic       tick;
   logic       start;
   logic       hit_lava;
   logic       hit_exit;
   logic       hit_ckpt;
   logic       hit_goal;
`ifdef LEVEL_SEQUENCER_CHECKPOINT_EN
   logic [9:0] ckpt_x;
   logic [9:0] ckpt_y;
`endif
   logic [2:0] level;
   logic [9:0] spawn_x;
   logic [9:0] spawn_y;
   logic       load_pos;
   logic       move_en;
   logic [2:0] lives;
   logic [2:0] state_o;

   modport master (
`ifdef LEVEL_SEQUENCER_CHECKPOINT_EN
      input  ckpt_x, ckpt_y,
`endif
      input  tick, start, hit_lava, hit_exit, hit_ckpt, hit_goal,
      output level, spawn_x, spawn_y, load_pos, move_en, lives, state_o
   );

   modport slave (
`ifdef LEVEL_SEQUENCER_CHECKPOINT_EN
      output ckpt_x, ckpt_y,
`endif
      output tick, start, hit_lava, hit_exit, hit_ckpt, hit_goal,
      input  level, spawn_x, spawn_y, load_pos, move_en, lives, state_o
   );
endinterface

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow FSM for the eight-level platformer (level, spawn, freeze, lives).
// Latency: a hit sampled at edge N updates state/move_en right after edge N; all outputs registered.
// Backpressure: none; hits are sampled every clk, freeze intervals are paced by tick.
// Ports: clk, rst_n (asserts asynchronously, deasserts through a two-flop synchroniser),
//        sq (master modport): tick/start/hit_* in; level, spawn_x/y, load_pos, move_en, lives, state_o out.
// Optional: `define LEVEL_SEQUENCER_CHECKPOINT_EN makes hit_ckpt latch ckpt_x/ckpt_y as the respawn point.
module level_sequencer #(
   parameter int LIVES       = 3,
   parameter int DEATH_TICKS = 30,
   parameter int ADV_TICKS   = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   level_sequencer_if.master sq
);

   localparam int CNT_MAX = (DEATH_TICKS > ADV_TICKS) ? DEATH_TICKS : ADV_TICKS;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [9:0] L0_X       = 10'd304;
   localparam logic [9:0] LN_X       = 10'd160;
   localparam logic [9:0] SPAWN_Y    = 10'd220;
   localparam logic [2:0] LAST_LEVEL = 3'd7;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SPAWN    = 3'd1,
      PLAY     = 3'd2,
      DEATH    = 3'd3,
      ADVANCE  = 3'd4,
      WIN      = 3'd5,
      GAMEOVER = 3'd6
   } state_t;

   // Reset asserts immediately, but releases only after two clean clk edges.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   state_t           state_q, state_d;
   logic [2:0]       level_q, level_d;
   logic [2:0]       lives_q, lives_d;
   logic [9:0]       spawn_x_q, spawn_x_d;
   logic [9:0]       spawn_y_q, spawn_y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_pos_q;
   logic             move_en_q;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      lives_d   = lives_q;
      spawn_x_d = spawn_x_q;
      spawn_y_d = spawn_y_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         IDLE, WIN, GAMEOVER: begin
            if (sq.start) begin
               state_d   = SPAWN;
               level_d   = 3'd0;
               lives_d   = 3'(LIVES);
               spawn_x_d = L0_X;
               spawn_y_d = SPAWN_Y;
            end
         end
         SPAWN: state_d = PLAY;
         PLAY: begin
            // Priority chain: lava, goal (last level only), exit (not last level), checkpoint.
            if (sq.hit_lava) begin
               state_d = DEATH;
               if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
            end else if (sq.hit_goal && level_q == LAST_LEVEL) begin
               state_d = WIN;
            end else if (sq.hit_exit && level_q != LAST_LEVEL) begin
               state_d   = ADVANCE;
               level_d   = level_q + 3'd1;
               // Every level past the first shares one spawn point.
               spawn_x_d = LN_X;
               spawn_y_d = SPAWN_Y;
            end else if (sq.hit_ckpt) begin
               // A checkpoint only moves the respawn point; play carries on.
               state_d = PLAY;
`ifdef LEVEL_SEQUENCER_CHECKPOINT_EN
               spawn_x_d = sq.ckpt_x;
               spawn_y_d = sq.ckpt_y;
`endif
            end
         end
         DEATH: begin
            // The spawn registers already hold the respawn point (table entry for the
            // current level, or the latched checkpoint), so they stay stable into SPAWN.
            if (cnt_q == CNT_W'(DEATH_TICKS)) state_d = (lives_q == 3'd0) ? GAMEOVER : SPAWN;
            else if (sq.tick)                 cnt_d   = cnt_q + 1'b1;
         end
         ADVANCE: begin
            if (cnt_q == CNT_W'(ADV_TICKS)) state_d = SPAWN;
            else if (sq.tick)               cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // The entry cycle never counts a tick: the counter restarts on every state change.
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         level_q    <= 3'd0;
         lives_q    <= 3'(LIVES);
         spawn_x_q  <= L0_X;
         spawn_y_q  <= SPAWN_Y;
         cnt_q      <= '0;
         load_pos_q <= 1'b0;
         move_en_q  <= 1'b0;
      end else begin
         level_q    <= level_d;
         lives_q    <= lives_d;
         spawn_x_q  <= spawn_x_d;
         spawn_y_q  <= spawn_y_d;
         cnt_q      <= cnt_d;
         // Registered from the next state so both flags line up with state_q.
         load_pos_q <= (state_d == SPAWN);
         move_en_q  <= (state_d == PLAY);
      end
   end

   assign sq.level    = level_q;
   assign sq.lives    = lives_q;
   assign sq.spawn_x  = spawn_x_q;
   assign sq.spawn_y  = spawn_y_q;
   assign sq.load_pos = load_pos_q;
   assign sq.move_en  = move_en_q;
   assign sq.state_o  = state_q;

endmodule
